// File: rtl/dual_port_memory_pkg.sv
// Shared width defaults and sizing helper for the dual-port memory.
package dual_port_memory_pkg;

    localparam int DPM_ADDR_WIDTH = 4;
    localparam int DPM_DATA_WIDTH = 8;

    // Number of words addressable by an address of the given width.
    function automatic int dpm_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/dual_port_memory.sv
// Simple dual-port memory: one write port, one registered read port, single clock.
// Define DUAL_PORT_MEMORY_WRITE_FIRST_EN for write-first same-address behaviour (default read-first).
module dual_port_memory
    import dual_port_memory_pkg::*;
#(
    parameter int ADDR_WIDTH = DPM_ADDR_WIDTH,
    parameter int DATA_WIDTH = DPM_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  rd_valid
);

    localparam int DEPTH = dpm_depth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] read_word;

    // The array is built from resettable flops so reset can clear every word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= din;
        end
    end

`ifdef DUAL_PORT_MEMORY_WRITE_FIRST_EN
    always_comb begin
        read_word = mem[rd_addr];
        if (wr_en && (wr_addr == rd_addr)) begin
            read_word = din;
        end
    end
`else
    // Read-first: the array still holds the old word during a colliding write.
    always_comb begin
        read_word = mem[rd_addr];
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout     <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                dout <= read_word;
            end
        end
    end

endmodule

// File: tb/tb_dual_port_memory.sv
// Self-checking bench for dual_port_memory using a reference model and a scoreboard queue.
// Honours DUAL_PORT_MEMORY_WRITE_FIRST_EN when predicting same-address collisions.
module tb_dual_port_memory;

    localparam int AW = 4;
    localparam int DW = 8;

    logic          clk;
    logic          rst_n;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] din;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] dout;
    logic          rd_valid;

    logic [DW-1:0] tb_mem [1 << AW];
    logic [DW-1:0] sb_queue [$];
    logic [DW-1:0] last_dout;
    int            check_count;
    int            pass_count;

    dual_port_memory #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .din      (din),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .dout     (dout),
        .rd_valid (rd_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end else begin
            pass_count++;
        end
    endtask

    task automatic clearModel();
        for (int i = 0; i < (1 << AW); i++) begin
            tb_mem[i] = '0;
        end
        sb_queue.delete();
        last_dout = '0;
    endtask

    // Drives one cycle of operations, predicts the read result, then checks outputs after the edge.
    task automatic applyStimulus(input string tag, input logic we, input logic [AW-1:0] wa,
                                 input logic [DW-1:0] d, input logic re, input logic [AW-1:0] ra);
        logic [DW-1:0] exp_word;
        logic          exp_valid;
        logic [DW-1:0] got_word;
        wr_en   = we;
        wr_addr = wa;
        din     = d;
        rd_en   = re;
        rd_addr = ra;
        exp_valid = re;
        exp_word  = tb_mem[ra];
`ifdef DUAL_PORT_MEMORY_WRITE_FIRST_EN
        if (we && (wa == ra)) exp_word = d;
`endif
        if (re) sb_queue.push_back(exp_word);
        if (we) tb_mem[wa] = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        checkOutput({tag, "_rd_valid"}, 32'(rd_valid), 32'(exp_valid));
        if (rd_valid) begin
            if (sb_queue.size() == 0) begin
                checkOutput({tag, "_sb_underflow"}, 32'(sb_queue.size()), 32'd1);
            end else begin
                got_word = sb_queue.pop_front();
                checkOutput({tag, "_dout"}, 32'(dout), 32'(got_word));
                last_dout = got_word;
            end
        end else begin
            checkOutput({tag, "_dout_hold"}, 32'(dout), 32'(last_dout));
        end
    endtask

    initial begin
        check_count = 0;
        pass_count  = 0;
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        din     = '0;
        rd_en   = 1'b0;
        rd_addr = '0;
        clearModel();

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_dout", 32'(dout), 32'h0);
        checkOutput("reset_rd_valid", 32'(rd_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus("unwritten5", 1'b0, 4'd0, 8'h00, 1'b1, 4'd5);
        applyStimulus("wr2", 1'b1, 4'd2, 8'hA5, 1'b0, 4'd0);
        applyStimulus("rd2", 1'b0, 4'd0, 8'h00, 1'b1, 4'd2);
        for (int i = 0; i < 3; i++) begin
            applyStimulus("idle_hold", 1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
        end

        applyStimulus("rd7_pre", 1'b0, 4'd0, 8'h00, 1'b1, 4'd7);
        applyStimulus("collide7", 1'b1, 4'd7, 8'h3C, 1'b1, 4'd7);
        applyStimulus("rd7_post", 1'b0, 4'd0, 8'h00, 1'b1, 4'd7);

        applyStimulus("wr9_rd2", 1'b1, 4'd9, 8'h5A, 1'b1, 4'd2);
        applyStimulus("rd9", 1'b0, 4'd0, 8'h00, 1'b1, 4'd9);

        applyStimulus("wr15", 1'b1, 4'd15, 8'hFF, 1'b0, 4'd0);
        applyStimulus("wr0", 1'b1, 4'd0, 8'h11, 1'b0, 4'd0);
        applyStimulus("rd15", 1'b0, 4'd0, 8'h00, 1'b1, 4'd15);
        applyStimulus("rd0", 1'b0, 4'd0, 8'h00, 1'b1, 4'd0);

        for (int i = 0; i < 40; i++) begin
            applyStimulus("random", 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                          8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                          4'($urandom_range(0, 15)));
        end

        applyStimulus("wr2_again", 1'b1, 4'd2, 8'hA5, 1'b0, 4'd0);
        applyStimulus("rd2_prereset", 1'b0, 4'd0, 8'h00, 1'b1, 4'd2);

        // Pulse reset between edges with a read pending; it must be aborted.
        rd_en   = 1'b1;
        rd_addr = 4'd2;
        wr_en   = 1'b1;
        wr_addr = 4'd4;
        din     = 8'h77;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_dout", 32'(dout), 32'h0);
        checkOutput("async_rst_rd_valid", 32'(rd_valid), 32'h0);
        @(posedge clk);
        #1;
        checkOutput("in_rst_rd_valid", 32'(rd_valid), 32'h0);
        checkOutput("in_rst_dout", 32'(dout), 32'h0);
        rd_en = 1'b0;
        wr_en = 1'b0;
        #2;
        rst_n = 1'b1;
        clearModel();

        applyStimulus("post_rst_rd2", 1'b0, 4'd0, 8'h00, 1'b1, 4'd2);
        applyStimulus("post_rst_rd4", 1'b0, 4'd0, 8'h00, 1'b1, 4'd4);
        applyStimulus("post_rst_rd15", 1'b0, 4'd0, 8'h00, 1'b1, 4'd15);
        applyStimulus("post_rst_idle", 1'b0, 4'd0, 8'h00, 1'b0, 4'd0);

        checkOutput("sb_leftover", 32'(sb_queue.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
